// File: rtl/tlb_xcpt_pkg.sv
// tlb_xcpt_pkg: shared types for the TLB exception unit.
// Holds the lookup FSM state enum and the permission-vector slot indices.
package tlb_xcpt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESP,
    S_DIRTY_REQ,
    S_DIRTY_WAIT
  } xcpt_state_e;

  localparam int PERM_R   = 0;
  localparam int PERM_W   = 1;
  localparam int PERM_X   = 2;
  localparam int NUM_PERM = 3;

endpackage

// File: rtl/tlb_perm_vec.sv
// tlb_perm_vec: combinational read/write/execute permission vectors.
// In: status bits, per-entry flags, PMA perms. Out: o_ok[PERM_*][ENTRIES:0].
module tlb_perm_vec
  import tlb_xcpt_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                             i_priv_s,
  input  logic                             i_pum,
  input  logic                             i_mxr,
  input  logic [ENTRIES-1:0]               i_u,
  input  logic [ENTRIES-1:0]               i_sw,
  input  logic [ENTRIES-1:0]               i_sx,
  input  logic [ENTRIES-1:0]               i_sr,
  input  logic [ENTRIES-1:0]               i_xr,
  input  logic                             i_prot_r,
  input  logic                             i_prot_w,
  input  logic                             i_prot_x,
  output logic [NUM_PERM-1:0][ENTRIES:0]   o_ok
);

  logic [ENTRIES-1:0] w_priv_ok;
  logic [ENTRIES-1:0] w_rd;

  always_comb begin
    // Supervisor may touch user pages only when PUM is clear.
    w_priv_ok = i_priv_s ? ~(i_pum ? i_u : '0) : i_u;
    // MXR makes executable pages readable.
    w_rd = i_sr | (i_mxr ? i_xr : '0);
    o_ok = '0;
    o_ok[PERM_R] = {i_prot_r, w_priv_ok & w_rd};
    o_ok[PERM_W] = {i_prot_w, w_priv_ok & i_sw};
    o_ok[PERM_X] = {i_prot_x, w_priv_ok & i_sx};
  end

endmodule

// File: rtl/tlb_xcpt_unit.sv
// tlb_xcpt_unit: registered permission check plus dirty-bit update for L1 TLB.
// Ports: req/resp handshakes, per-entry flags, PMA perms, PTW dirty request.
module tlb_xcpt_unit
  import tlb_xcpt_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_store,
  input  logic [ENTRIES:0]   i_req_hits,
  input  logic               i_req_bad_va,
  input  logic               i_priv_s,
  input  logic               i_pum,
  input  logic               i_mxr,
  input  logic [ENTRIES-1:0] i_u_array,
  input  logic [ENTRIES-1:0] i_sw_array,
  input  logic [ENTRIES-1:0] i_sx_array,
  input  logic [ENTRIES-1:0] i_sr_array,
  input  logic [ENTRIES-1:0] i_xr_array,
  input  logic [ENTRIES-1:0] i_dirty_array,
  input  logic               i_prot_r,
  input  logic               i_prot_w,
  input  logic               i_prot_x,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic               o_resp_xcpt_ld,
  output logic               o_resp_xcpt_st,
  output logic               o_resp_xcpt_if,
  output logic               o_resp_replay,
  output logic               o_dirty_req_valid,
  input  logic               i_dirty_req_ready,
  output logic [IDXW-1:0]    o_dirty_req_idx,
  input  logic               i_dirty_ack,
  input  logic               i_dirty_fail
);

  xcpt_state_e r_state;
  xcpt_state_e w_state_nxt;

  logic [NUM_PERM-1:0][ENTRIES:0] w_ok;
  logic               w_xcpt_ld;
  logic               w_xcpt_st;
  logic               w_xcpt_if;
  logic [ENTRIES-1:0] w_dirty_vec;
  logic               w_dirty_need;
  logic [IDXW-1:0]    w_dirty_idx;
  logic               w_accept;

  logic               r_xcpt_ld;
  logic               r_xcpt_st;
  logic               r_xcpt_if;
  logic               r_replay;
  logic [IDXW-1:0]    r_idx;

  tlb_perm_vec #(
    .ENTRIES (ENTRIES)
  ) u_perm (
    .i_priv_s (i_priv_s),
    .i_pum    (i_pum),
    .i_mxr    (i_mxr),
    .i_u      (i_u_array),
    .i_sw     (i_sw_array),
    .i_sx     (i_sx_array),
    .i_sr     (i_sr_array),
    .i_xr     (i_xr_array),
    .i_prot_r (i_prot_r),
    .i_prot_w (i_prot_w),
    .i_prot_x (i_prot_x),
    .o_ok     (w_ok)
  );

  always_comb begin
    w_xcpt_ld = i_req_bad_va | |(~w_ok[PERM_R] & i_req_hits);
    w_xcpt_st = i_req_bad_va | |(~w_ok[PERM_W] & i_req_hits);
    w_xcpt_if = i_req_bad_va | |(~w_ok[PERM_X] & i_req_hits);
    // PMA entry (top hit bit) is excluded from the dirty check.
    w_dirty_vec  = i_req_hits[ENTRIES-1:0] & ~i_dirty_array;
    w_dirty_need = i_req_store & ~w_xcpt_st & |w_dirty_vec;
    // Downward scan so the lowest set bit wins.
    w_dirty_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_dirty_vec[i]) w_dirty_idx = IDXW'(i);
    end
  end

  assign w_accept = (r_state == S_IDLE) & i_req_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    o_req_ready       = 1'b0;
    o_resp_valid      = 1'b0;
    o_dirty_req_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid)
          w_state_nxt = w_dirty_need ? S_DIRTY_REQ : S_RESP;
      end
      S_DIRTY_REQ: begin
        o_dirty_req_valid = 1'b1;
        if (i_dirty_req_ready) w_state_nxt = S_DIRTY_WAIT;
      end
      S_DIRTY_WAIT: begin
        if (i_dirty_ack) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_xcpt_ld <= 1'b0;
      r_xcpt_st <= 1'b0;
      r_xcpt_if <= 1'b0;
      r_replay  <= 1'b0;
      r_idx     <= '0;
    end else if (w_accept) begin
      r_xcpt_ld <= w_xcpt_ld;
      r_xcpt_st <= w_xcpt_st;
      r_xcpt_if <= w_xcpt_if;
      r_replay  <= 1'b0;
      r_idx     <= w_dirty_idx;
    end else if (r_state == S_DIRTY_WAIT && i_dirty_ack) begin
      // A failed dirty update turns the store into a fault.
      r_xcpt_st <= i_dirty_fail;
      r_replay  <= 1'b1;
    end
  end

  assign o_resp_xcpt_ld  = r_xcpt_ld;
  assign o_resp_xcpt_st  = r_xcpt_st;
  assign o_resp_xcpt_if  = r_xcpt_if;
  assign o_resp_replay   = r_replay;
  assign o_dirty_req_idx = r_idx;

endmodule
